mem_word_sequencer: RTL and testbench

- Sits between the CPU load/store path and the byte-wide main memory (8-bit write data, 16-bit address, combinational read, synchronous write).
- Converts one 16-bit word or 8-bit byte request into one or two sequential byte accesses, little-endian.
- Assembles read bytes into a 16-bit result and signals completion with a one-cycle done pulse.

---
 rtl/mem_seq_pkg.sv | 12 +
 rtl/mem_wait_counter.sv | 21 ++
 rtl/mem_word_sequencer.sv | 137 +++++++++++++
 tb/tb_mem_word_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared state encoding and request-size constants for the memory word sequencer.
package mem_seq_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
endpackage

// File: rtl/mem_wait_counter.sv
// Per-byte access length counter: counts from 0 and flags the final cycle of a byte access.
module mem_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic at_lim
);
  localparam logic [3:0] LIM = 4'(WAIT_CYCLES);

  logic [3:0] cnt_q, cnt_d;

  always_comb cnt_d = clr ? 4'd0 : cnt_q + 4'd1;

  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;

  assign at_lim = (cnt_q == LIM);
endmodule

// File: rtl/mem_word_sequencer.sv
// Splits byte/word load-store requests into little-endian byte accesses on a byte-wide memory.
// Optional MISALIGN_ERR_EN: odd-address word requests complete immediately with err set.
module mem_word_sequencer
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [15:0]       mem_dout
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              size_q, size_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              access, at_lim, last;
  logic              unused_dout_hi;

  assign unused_dout_hi = ^mem_dout[15:8];

  assign access = (state_q == LO) || (state_q == HI);
  assign last   = access && at_lim;

  // Held clear outside accesses and cleared at the final cycle, so each byte restarts at 0.
  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (!access || at_lim),
    .at_lim (at_lim)
  );

`ifdef MISALIGN_ERR_EN
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MISALIGN_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (req) begin
        addr_d  = addr;
        we_d    = we;
        size_d  = size;
        wdata_d = wdata;
        state_d = LO;
`ifdef MISALIGN_ERR_EN
        err_d   = (size == SIZE_WORD) && addr[0];
        if (err_d) state_d = DONE;
`endif
      end
      LO: if (last) begin
        if (!we_q) begin
          rdata_d[7:0] = mem_dout[7:0];
          if (size_q == SIZE_BYTE) rdata_d[15:8] = 8'h00;
        end
        state_d = (size_q == SIZE_WORD) ? HI : DONE;
      end
      HI: if (last) begin
        if (!we_q) rdata_d[15:8] = mem_dout[7:0];
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end

`ifdef MISALIGN_ERR_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  assign err = done && err_q;
`else
  assign err = 1'b0;
`endif

  // Memory strobes decode only registered state so req/addr never reach the memory ports.
  always_comb begin
    mem_addr  = '0;
    mem_din   = 8'h00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state_q == LO) begin
      mem_addr  = addr_q;
      mem_din   = wdata_q[7:0];
      mem_read  = !we_q;
      mem_write = we_q && at_lim;
    end else if (state_q == HI) begin
      mem_addr  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      mem_din   = wdata_q[15:8];
      mem_read  = !we_q;
      mem_write = we_q && at_lim;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign rdata = rdata_q;
endmodule

// File: tb/tb_mem_word_sequencer.sv
// Directed bench: zero-wait instance driven from a vector table plus hand sequences; second instance with WAIT_CYCLES=2.
module tb_mem_word_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we = 1'b0, size = 1'b0;
  logic [15:0] addr = '0, wdata = '0;

  logic        busy0, done0, err0, mem_read0, mem_write0;
  logic [15:0] rdata0, mem_addr0, mem_dout0;
  logic [7:0]  mem_din0;
  logic        busy1, done1, err1, mem_read1, mem_write1;
  logic [15:0] rdata1, mem_addr1, mem_dout1;
  logic [7:0]  mem_din1;

  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem1 [0:65535];
  logic        pl_we = 1'b0;
  int          pl_sel = 0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_word_sequencer #(.ADDR_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy0), .done(done0), .err(err0), .rdata(rdata0), .mem_addr(mem_addr0),
    .mem_din(mem_din0), .mem_read(mem_read0), .mem_write(mem_write0), .mem_dout(mem_dout0));

  mem_word_sequencer #(.ADDR_W(16), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .err(err1), .rdata(rdata1), .mem_addr(mem_addr1),
    .mem_din(mem_din1), .mem_read(mem_read1), .mem_write(mem_write1), .mem_dout(mem_dout1));

  // Garbage when not reading, so a capture outside mem_read shows up as bad data.
  assign mem_dout0 = mem_read0 ? {8'h00, mem0[mem_addr0]} : 16'hDEAD;
  assign mem_dout1 = mem_read1 ? {8'h00, mem1[mem_addr1]} : 16'hDEAD;

  always @(posedge clk) begin
    if (pl_we && pl_sel == 0) mem0[pl_addr] <= pl_data;
    else if (mem_write0)      mem0[mem_addr0] <= mem_din0;
    if (pl_we && pl_sel == 1) mem1[pl_addr] <= pl_data;
    else if (mem_write1)      mem1[mem_addr1] <= mem_din1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pre(input int which, input logic [15:0] a, input logic [7:0] d);
    pl_sel = which; pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Issue one request to dut0 from IDLE; returns latency (cycles after accept edge) and strobe counts.
  task automatic run0(input logic w, input logic s, input logic [15:0] a, input logic [15:0] d,
                      output int lat, output int rdc, output int wrc, output logic e_seen);
    req0 = 1'b1; we = w; size = s; addr = a; wdata = d;
    @(posedge clk); #1;
    req0 = 1'b0;
    lat = 0; rdc = 0; wrc = 0; e_seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      lat = c;
      if (mem_read0)  rdc++;
      if (mem_write0) wrc++;
      if (done0) begin e_seen = err0; break; end
      @(posedge clk); #1;
    end
    chk("done_timeout", 32'(done0), 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        w;
    logic        s;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, rdc, wrc;
    logic e;

    vecs[0] = '{1'b0, 1'b1, 16'h0100, 16'h0000, 16'h1234, 3, 2, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h1234, 3, 0, 2, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 16'h0101, 16'h0000, 16'h0012, 2, 1, 0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0300, 16'h12AB, 16'h0012, 2, 0, 1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h0200, 16'h0000, 16'hBEEF, 3, 2, 0, 1'b0};
`ifdef MISALIGN_ERR_EN
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 1, 0, 0, 1'b1};
`else
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h7856, 3, 2, 0, 1'b0};
`endif
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0078, 2, 1, 0, 1'b0};

    @(posedge clk); #1;
    pre(0, 16'h0100, 8'h34); pre(0, 16'h0101, 8'h12);
    pre(0, 16'hFFFF, 8'h56); pre(0, 16'h0000, 8'h78);
    pre(0, 16'h0200, 8'h00); pre(0, 16'h0201, 8'h00); pre(0, 16'h0300, 8'h00);
    pre(0, 16'h0400, 8'h00); pre(0, 16'h0500, 8'h00); pre(0, 16'h0501, 8'h00);
    pre(1, 16'h0200, 8'h00); pre(1, 16'h0201, 8'h00);

    chk("rst_rdata", 32'(rdata0), 32'h0);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_err", 32'(err0), 32'h0);
    chk("rst_mem_strobes", {30'd0, mem_read0, mem_write0}, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr0), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run0(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, lat, rdc, wrc, e);
      $display("vector %0d: lat=%0d rdata=%h", i, lat, rdata0);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdata", i), 32'(rdata0), 32'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_read_cycles", i), 32'(rdc), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_write_cycles", i), 32'(wrc), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_idle_after", i), 32'(busy0), 32'h0);
    end
    chk("store_lo_byte", 32'(mem0[16'h0200]), 32'hEF);
    chk("store_hi_byte", 32'(mem0[16'h0201]), 32'hBE);
    chk("byte_store", 32'(mem0[16'h0300]), 32'hAB);

    // req held from LO through DONE must not be queued.
    req0 = 1'b1; we = 1'b0; size = 1'b0; addr = 16'h0101; wdata = 16'h0;
    @(posedge clk); #1;
    we = 1'b1; size = 1'b1; addr = 16'h0400; wdata = 16'h5555;
    chk("ign_busy_lo", 32'(busy0), 32'h1);
    @(posedge clk); #1;
    chk("ign_done", 32'(done0), 32'h1);
    chk("ign_rdata", 32'(rdata0), 32'h0012);
    @(posedge clk); #1;
    req0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("ign_stays_idle", {30'd0, busy0, mem_write0}, 32'h0);
      @(posedge clk); #1;
    end
    chk("ign_no_write", 32'(mem0[16'h0400]), 32'h00);

    // WAIT_CYCLES=2 word store on dut1.
    req1 = 1'b1; we = 1'b1; size = 1'b1; addr = 16'h0200; wdata = 16'hA5C3;
    @(posedge clk); #1;
    req1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("w2_addr_c%0d", c), 32'(mem_addr1),
          (c <= 3) ? 32'h0200 : (c <= 6) ? 32'h0201 : 32'h0);
      chk($sformatf("w2_write_c%0d", c), 32'(mem_write1), (c == 3 || c == 6) ? 32'h1 : 32'h0);
      chk($sformatf("w2_done_c%0d", c), 32'(done1), (c == 7) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
    end
    chk("w2_mem_lo", 32'(mem1[16'h0200]), 32'hC3);
    chk("w2_mem_hi", 32'(mem1[16'h0201]), 32'hA5);
    chk("w2_rdata", 32'(rdata1), 32'h0);

    // Reset during HI of a word store.
    req0 = 1'b1; we = 1'b1; size = 1'b1; addr = 16'h0500; wdata = 16'h6677;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    chk("rh_write_in_hi", {15'd0, mem_write0, mem_addr0}, {15'd0, 1'b1, 16'h0501});
    #2 rst = 1'b1;
    #1;
    chk("rh_write_drop", 32'(mem_write0), 32'h0);
    chk("rh_busy", 32'(busy0), 32'h0);
    chk("rh_mem_addr", 32'(mem_addr0), 32'h0);
    chk("rh_mem_din", 32'(mem_din0), 32'h0);
    chk("rh_rdata", 32'(rdata0), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rh_lo_written", 32'(mem0[16'h0500]), 32'h77);
    chk("rh_hi_not_written", 32'(mem0[16'h0501]), 32'h00);
    chk("rh_idle", {30'd0, busy0, done0}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
